csa_add_arbiter: RTL and testbench
==================================

Name: csa_add_arbiter

Overview:
- Shares one csa_41bit carry-select adder among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Operands are latched, added, and the sum is returned on a single response channel tagged with the requester id.
- Sits between the lane-level requesters and the shared 41-bit adder datapath.

Parameters:
- WIDTH, 41: operand and sum width. Fixed by the csa_41bit instance; other values are unsupported.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the requester id, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_term1  in  NUM_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH].
- req_term2  in  NUM_REQ*WIDTH  packed operand B; same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  term1+term2, mod 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_id  out  ID_W  index of the requester that owns the result.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, operand registers=0.
  - req_ready=0 while rst=1, regardless of state.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning upward from rr_ptr, wrapping NUM_REQ-1 to 0.
  - req_ready[winner]=1 combinationally in that cycle; all other req_ready bits are 0.
  - On the clock edge: latch term1, term2 and winner into op_a, op_b, op_id; rr_ptr <= (winner+1) mod NUM_REQ; go to CALC.
  - If no req_valid is high: stay in IDLE; rr_ptr unchanged.
- CALC:
  - The adder sees op_a and op_b with cin=0.
  - On the edge: rsp_sum <= sum, rsp_cout <= cout, rsp_id <= op_id, rsp_valid <= 1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable.
  - If rsp_ready=1 on the edge: rsp_valid <= 0 and go to IDLE. Otherwise stay in RESP indefinitely (backpressure).
  - req_ready=0.
- Timing:
  - rsp_valid rises 2 cycles after the grant edge.
  - Minimum spacing between grants is 3 cycles (grant, calc, resp with immediate ready).
- Requester protocol:
  - A requester holds valid and its operands stable until it is granted.
  - Dropping valid before the grant is legal; such a request is simply not served.
- req_ready is asserted only in IDLE and never for a requester whose req_valid=0.
- Fairness: any continuously-valid requester is granted within NUM_REQ grants.
- rsp_valid, rsp_sum, rsp_cout and rsp_id are registered outputs. req_ready is the only combinational output.
- Reset mid-operation: any state returns to IDLE on the next edge; an in-flight operation and its response are discarded; rr_ptr returns to 0.
- Simultaneous valids in IDLE: only the round-robin winner is served; the others wait.

Optional Feature:
- Macro: CSA_ADD_ARB_PERF_EN.
- When defined, two extra outputs are added:
  - op_count [15:0]: increments on each response handshake (rsp_valid & rsp_ready).
  - stall_count [15:0]: increments on each cycle with rsp_valid=1 and rsp_ready=0.
- Both counters saturate at 0xFFFF and reset to 0.
- When not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid=0001, term1=0x00000000005, term2=0x00000000003 -> req_ready=0001 for one cycle; 2 cycles later rsp_valid=1, rsp_sum=0x00000000008, rsp_cout=0, rsp_id=0.
- Carry out across all blocks: term1=0x1FFFFFFFFFF, term2=0x00000000001 on requester 2 -> rsp_sum=0, rsp_cout=1, rsp_id=2. Also 0x15555555555+0x0AAAAAAAAAA -> 0x1FFFFFFFFFF, cout=0.
- Round robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; grants spaced exactly 3 cycles apart; rsp_id follows the same sequence.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_sum stable; no req_ready asserted. With CSA_ADD_ARB_PERF_EN: stall_count=5, then op_count=1 after ready.
- Reset mid-operation: assert rst in CALC -> next cycle rsp_valid=0, state IDLE; the following grant goes to requester 0 if valid.
- Wrap with sparse requests: rr_ptr=3, req_valid=0101 -> grant requester 0, then requester 2.

Source files
------------

// File: rtl/csa_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : csa_add_arbiter (plus helper csa_41bit)
// Purpose  : Shares one 41-bit carry-select adder among NUM_REQ requesters.
//            Round-robin arbitration, valid/ready per request port, a single
//            registered response channel tagged with the requester id.
// Ports    : clk, rst (sync, active-high)
//            req_valid/req_ready [NUM_REQ]   request handshake
//            req_term1/req_term2 [NUM_REQ*WIDTH] packed operands
//            rsp_valid/rsp_ready, rsp_sum [WIDTH], rsp_cout, rsp_id [ID_W]
//            op_count/stall_count [16]  (only with CSA_ADD_ARB_PERF_EN)
// Options  : define CSA_ADD_ARB_PERF_EN to add the saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================

// 41-bit carry-select adder: a 9-bit ripple head followed by four 8-bit
// blocks, each computing both carry-in cases and selecting on the real carry.
module csa_41bit (
  input  logic [40:0] a,
  input  logic [40:0] b,
  input  logic        cin,
  output logic [40:0] sum,
  output logic        cout
);
  logic [4:0] carry;

  assign {carry[0], sum[8:0]} = {1'b0, a[8:0]} + {1'b0, b[8:0]} + {9'd0, cin};

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [8:0] s0;
    logic [8:0] s1;
    assign s0 = {1'b0, a[9+g*8 +: 8]} + {1'b0, b[9+g*8 +: 8]};
    assign s1 = {1'b0, a[9+g*8 +: 8]} + {1'b0, b[9+g*8 +: 8]} + 9'd1;
    assign sum[9+g*8 +: 8] = carry[g] ? s1[7:0] : s0[7:0];
    assign carry[g+1]      = carry[g] ? s1[8]   : s0[8];
  end

  assign cout = carry[4];
endmodule

module csa_add_arbiter #(
  parameter int WIDTH   = 41,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_term1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_term2,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [ID_W-1:0]            rsp_id
`ifdef CSA_ADD_ARB_PERF_EN
  ,
  output logic [15:0]                op_count,
  output logic [15:0]                stall_count
`endif
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;

  // Round-robin pick: first valid requester scanning upward from rr_ptr,
  // wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    int cand;
    any_valid = 1'b0;
    winner    = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_valid && req_valid[ID_W'(cand)]) begin
        any_valid = 1'b1;
        winner    = ID_W'(cand);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_term1[i*WIDTH +: WIDTH];
        sel_b = req_term2[i*WIDTH +: WIDTH];
      end
    end
  end

  csa_41bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // req_ready is the only combinational output; it is forced low during
  // reset so no requester sees a grant that the reset edge would discard.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = CALC;
          if (!rst) req_ready[winner] = 1'b1;
        end
      end
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= winner;
            rr_ptr <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
          end
        end
        CALC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ADD_ARB_PERF_EN
  // Saturating counters: completed handshakes and backpressured cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rsp_valid && rsp_ready && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
      if (rsp_valid && !rsp_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_csa_add_arbiter
// Purpose  : Directed self-checking bench for csa_add_arbiter: reset values,
//            single request, carry propagation, round robin, backpressure,
//            reset mid-operation and sparse wrap-around arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_add_arbiter;
  localparam int W  = 41;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_term1 = '0;
  logic [NR*W-1:0]   req_term2 = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IW-1:0]     rsp_id;
`ifdef CSA_ADD_ARB_PERF_EN
  logic [15:0]       op_count;
  logic [15:0]       stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  csa_add_arbiter #(.WIDTH(W), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_term1   (req_term1),
    .req_term2   (req_term2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .rsp_id      (rsp_id)
`ifdef CSA_ADD_ARB_PERF_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_term1[k*W +: W] = a;
    req_term2[k*W +: W] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_sum !== '0) begin n_fail++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
    n_checks++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cout: got %b want 0", rsp_cout); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
`ifdef CSA_ADD_ARB_PERF_EN
    n_checks++; if (op_count !== 16'd0 || stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", op_count, stall_count); end
`endif
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b0;
    set_req(0, 41'h00000000005, 41'h00000000003);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_calc: ready=%b valid=%b want 0000/0", req_ready, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_sum !== 41'h00000000008) begin n_fail++; $display("FAIL single_sum: got %h want 00000000008", rsp_sum); end
    n_checks++; if (rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_cout_id: got %b/%0d want 0/0", rsp_cout, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_carry();
    // rr_ptr is 1 here; requester 2 alone wins.
    rsp_ready = 1'b0;
    set_req(2, 41'h1FFFFFFFFFF, 41'h00000000001);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL carry_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    n_checks++; if (rsp_sum !== '0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin n_fail++; $display("FAIL carry_full: sum=%h cout=%b id=%0d want 0/1/2", rsp_sum, rsp_cout, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    // rr_ptr is 3; scanning 3,0,1 picks requester 1.
    rsp_ready = 1'b0;
    set_req(1, 41'h15555555555, 41'h0AAAAAAAAAA);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL alt_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    n_checks++; if (rsp_sum !== 41'h1FFFFFFFFFF || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL alt_sum: sum=%h cout=%b id=%0d want 1ffffffffff/0/1", rsp_sum, rsp_cout, rsp_id); end
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_sum [4];
    logic [3:0]   exp_rdy;
    int           e;
    exp_sum[0] = 41'h010; exp_sum[1] = 41'h021; exp_sum[2] = 41'h032; exp_sum[3] = 41'h043;
    apply_reset();
    set_req(0, 41'h010, 41'h0);
    set_req(1, 41'h020, 41'h1);
    set_req(2, 41'h030, 41'h2);
    set_req(3, 41'h040, 41'h3);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      exp_rdy = 4'b0001 << e;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_rdy); end
      tick();
      n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_calc%0d: ready=%b valid=%b want 0000/0", g, req_ready, rsp_valid); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(e) || rsp_sum !== exp_sum[e] || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL rr_resp%0d: valid=%b id=%0d sum=%h ready=%b want 1/%0d/%h/0000", g, rsp_valid, rsp_id, rsp_sum, req_ready, e, exp_sum[e]);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    set_req(1, 41'h123, 41'h456);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 41'h579 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b sum=%h id=%0d ready=%b want 1/579/1/0000", i, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      tick();
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 41'h579) begin n_fail++; $display("FAIL bp_after: valid=%b sum=%h want 1/579", rsp_valid, rsp_sum); end
`ifdef CSA_ADD_ARB_PERF_EN
    n_checks++; if (stall_count !== 16'd5 || op_count !== 16'd0) begin n_fail++; $display("FAIL bp_stall_count: stall=%0d op=%0d want 5/0", stall_count, op_count); end
`endif
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
`ifdef CSA_ADD_ARB_PERF_EN
    n_checks++; if (op_count !== 16'd1 || stall_count !== 16'd5) begin n_fail++; $display("FAIL bp_op_count: op=%0d stall=%0d want 1/5", op_count, stall_count); end
`endif
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 2 after the backpressure scenario.
    rsp_ready = 1'b1;
    set_req(2, 41'h7, 41'h9);
    set_req(0, 41'h100, 41'h200);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmid_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready_calc: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_after_rst: valid=%b ready=%b want 0/0000", rsp_valid, req_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_regrant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 41'h300) begin n_fail++; $display("FAIL rmid_rsp: valid=%b id=%0d sum=%h want 1/0/300", rsp_valid, rsp_id, rsp_sum); end
    tick();
  endtask

  task automatic test_wrap_sparse();
    apply_reset();
    rsp_ready = 1'b1;
    set_req(2, 41'h1, 41'h1);
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = '0;
    tick();
    n_checks++; if (rsp_id !== 2'd2 || rsp_sum !== 41'h2) begin n_fail++; $display("FAIL wrap_setup: id=%0d sum=%h want 2/2", rsp_id, rsp_sum); end
    tick();
    // rr_ptr is now 3; with 0101 the scan 3,0 lands on requester 0.
    set_req(0, 41'hA, 41'hB);
    set_req(2, 41'hC, 41'hD);
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant0: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wrap_busy: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (rsp_id !== 2'd0 || rsp_sum !== 41'h15) begin n_fail++; $display("FAIL wrap_rsp0: id=%0d sum=%h want 0/15", rsp_id, rsp_sum); end
    tick();
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_grant2: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 41'h19) begin n_fail++; $display("FAIL wrap_rsp2: valid=%b id=%0d sum=%h want 1/2/19", rsp_valid, rsp_id, rsp_sum); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap_sparse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
